// File: rtl/systolic_array_ws.sv
// rtl/systolic_array_ws.sv - weight-stationary systolic GEMM tile with load/compute/drain control
module systolic_array_ws #(
    parameter int bit_width = 8,
    parameter int rows      = 4,
    parameter int cols      = 16,
    parameter int acc_width = 2*bit_width+$clog2(rows)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      signed_mode,
    input  logic                      keep_wt,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    input  logic [bit_width*cols-1:0] wt_in,
    input  logic                      act_valid,
    output logic                      act_ready,
    input  logic                      act_last,
    input  logic [bit_width*rows-1:0] act_in,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [acc_width*cols-1:0] out_data,
    output logic                      busy
);

    localparam int lat   = rows + cols;
    localparam int idx_w = (rows > 1) ? $clog2(rows) : 1;
    localparam int sk_d  = (rows > 1) ? rows - 1 : 1;
    localparam int dk_d  = (cols > 1) ? cols - 1 : 1;

    typedef enum logic [1:0] {EMPTY, LOADING, READY, DRAIN} state_t;

    state_t                 state, state_nx;
    logic                   run;
    logic                   mode;
    logic                   keep_q;
    logic [idx_w-1:0]       wt_cnt;
    logic                   wt_acc, act_acc;
    logic [bit_width-1:0]   wt   [rows][cols];
    logic [bit_width-1:0]   x0   [rows];
    logic [bit_width-1:0]   sk   [rows][sk_d];
    logic [bit_width-1:0]   a_sk [rows];
    logic [bit_width-1:0]   a_pe [rows][cols];
    logic [bit_width-1:0]   a_q  [rows][cols];
    logic [acc_width-1:0]   p_in [rows][cols];
    logic [acc_width-1:0]   p_q  [rows][cols];
    logic [acc_width-1:0]   dk   [cols][dk_d];
    logic [acc_width-1:0]   col_out [cols];
    logic [lat-1:0]         vld, lst;

    // Product of one operand pair, extended to accumulator width per operand mode
    function automatic logic [acc_width-1:0] mul_ext(input logic [bit_width-1:0] a,
                                                     input logic [bit_width-1:0] w,
                                                     input logic sm);
        logic signed [2*bit_width-1:0] as_, ws_, ps;
        logic        [2*bit_width-1:0] au, wu, pu;
        logic signed [acc_width-1:0]   es;
        as_ = (2*bit_width)'($signed(a));
        ws_ = (2*bit_width)'($signed(w));
        au  = (2*bit_width)'(a);
        wu  = (2*bit_width)'(w);
        ps  = as_ * ws_;
        pu  = au * wu;
        es  = acc_width'(ps);
        return sm ? es : acc_width'(pu);
    endfunction

    assign wt_acc  = wt_valid & wt_ready;
    assign act_acc = act_valid & act_ready;

    // Keeps ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (wt_acc) state_nx = (rows == 1) ? READY : LOADING;
            LOADING: if (wt_acc && wt_cnt == idx_w'(rows - 1)) state_nx = READY;
            READY:   if (act_acc && act_last) state_nx = DRAIN;
            DRAIN:   if (out_last) state_nx = keep_q ? READY : EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        wt_ready  = run && (state == EMPTY || state == LOADING);
        act_ready = (state == READY);
        busy      = (state != EMPTY);
    end

    // Beat counter, operand mode latched on first beat, retention flag latched on last vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_cnt <= '0;
            mode   <= 1'b0;
            keep_q <= 1'b0;
        end else begin
            if (wt_acc) wt_cnt <= (state_nx == READY) ? '0 : wt_cnt + 1'b1;
            if (wt_acc && state == EMPTY) mode <= signed_mode;
            if (act_acc && act_last) keep_q <= keep_wt;
        end
    end

    // Weight storage: one row per accepted beat, cleared when a tile is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt <= '{default: '0};
        end else if (state == DRAIN && out_last && !keep_q) begin
            wt <= '{default: '0};
        end else if (wt_acc) begin
            for (int c = 0; c < cols; c++)
                wt[wt_cnt][c] <= wt_in[c*bit_width +: bit_width];
        end
    end

    // Skew taps, PE operand routing and deskew taps
    always_comb begin
        for (int r = 0; r < rows; r++)
            a_sk[r] = (r == 0) ? x0[r] : sk[r][(r > 0) ? r - 1 : 0];
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                a_pe[r][c] = (c == 0) ? a_sk[r] : a_q[r][(c > 0) ? c - 1 : 0];
                p_in[r][c] = (r == 0) ? '0 : p_q[(r > 0) ? r - 1 : 0][c];
            end
        end
        for (int c = 0; c < cols; c++)
            col_out[c] = (c == cols - 1) ? p_q[rows-1][c] : dk[c][(c < cols - 1) ? cols - 2 - c : 0];
    end

    // Datapath: input capture, skew lines, PE grid, deskew lines, valid/last tracking, output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0        <= '{default: '0};
            sk        <= '{default: '0};
            a_q       <= '{default: '0};
            p_q       <= '{default: '0};
            dk        <= '{default: '0};
            vld       <= '0;
            lst       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int r = 0; r < rows; r++) begin
                x0[r] <= act_acc ? act_in[r*bit_width +: bit_width] : '0;
                for (int i = 0; i < sk_d; i++)
                    sk[r][i] <= (i == 0) ? x0[r] : sk[r][(i > 0) ? i - 1 : 0];
                for (int c = 0; c < cols; c++) begin
                    a_q[r][c] <= a_pe[r][c];
                    p_q[r][c] <= p_in[r][c] + mul_ext(a_pe[r][c], wt[r][c], mode);
                end
            end
            for (int c = 0; c < cols; c++) begin
                for (int i = 0; i < dk_d; i++)
                    dk[c][i] <= (i == 0) ? p_q[rows-1][c] : dk[c][(i > 0) ? i - 1 : 0];
                out_data[c*acc_width +: acc_width] <= col_out[c];
            end
            vld       <= {vld[lat-2:0], act_acc};
            lst       <= {lst[lat-2:0], act_acc & act_last};
            out_valid <= vld[lat-1];
            out_last  <= lst[lat-1];
        end
    end

endmodule

// File: tb/tb_systolic_array_ws.sv
// tb/tb_systolic_array_ws.sv - scoreboard bench for systolic_array_ws against a matrix-product model
module tb_systolic_array_ws;

    localparam int BW = 8;
    localparam int R  = 4;
    localparam int C  = 16;
    localparam int A  = 2*BW + $clog2(R);
    localparam int L  = R + C;
    localparam int W  = A*C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          signed_mode = 1'b0;
    logic          keep_wt = 1'b0;
    logic          wt_valid = 1'b0;
    logic          wt_ready;
    logic [BW*C-1:0] wt_in = '0;
    logic          act_valid = 1'b0;
    logic          act_ready;
    logic          act_last = 1'b0;
    logic [BW*R-1:0] act_in = '0;
    logic          out_valid;
    logic          out_last;
    logic [W-1:0]  out_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_cnt = 0;

    logic [BW-1:0] mw [R][C];
    logic          mode_m = 1'b0;

    logic [W-1:0]  exp_data_q[$];
    logic          exp_last_q[$];
    int            exp_due_q[$];

    systolic_array_ws dut (
        .clk(clk), .rst_n(rst_n), .signed_mode(signed_mode), .keep_wt(keep_wt),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_in(wt_in),
        .act_valid(act_valid), .act_ready(act_ready), .act_last(act_last), .act_in(act_in),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    // Column sums computed directly from the stored weight matrix
    function automatic logic [W-1:0] model(input logic [BW*R-1:0] av);
        logic [W-1:0] res;
        longint s, x, y;
        res = '0;
        for (int c = 0; c < C; c++) begin
            s = 0;
            for (int r = 0; r < R; r++) begin
                x = mode_m ? longint'($signed(av[r*BW +: BW])) : longint'(av[r*BW +: BW]);
                y = mode_m ? longint'($signed(mw[r][c])) : longint'(mw[r][c]);
                s += x * y;
            end
            res[c*A +: A] = s[A-1:0];
        end
        return res;
    endfunction

    // Monitor: pops the scoreboard on every presented result
    always @(negedge clk) begin
        if (out_valid) begin
            if (out_last) last_cnt++;
            if (exp_data_q.size() == 0) begin
                chk("unexpected_out", out_valid, 1'b0);
            end else begin
                chk("out_data", out_data, exp_data_q.pop_front());
                chk("out_last", out_last, exp_last_q.pop_front());
                chk("latency", cyc, exp_due_q.pop_front());
            end
        end
    end

    task automatic load_w(input logic sm, input bit poke);
        int t;
        signed_mode = sm;
        mode_m = sm;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) wt_in[c*BW +: BW] = mw[r][c];
            wt_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!wt_ready && t < 50) begin @(negedge clk); t++; end
            chk("wt_accept", wt_ready, 1'b1);
            @(posedge clk); #1;
            signed_mode = ~sm;
            if (poke && r == 1) begin
                wt_valid = 1'b0;
                act_valid = 1'b1;
                act_last = 1'b1;
                act_in = $urandom;
                @(negedge clk);
                chk("act_ready_loading", act_ready, 1'b0);
                chk("wt_ready_loading", wt_ready, 1'b1);
                @(posedge clk); #1;
                act_valid = 1'b0;
                act_last = 1'b0;
            end
        end
        wt_valid = 1'b0;
        signed_mode = 1'b0;
    endtask

    task automatic send_vec(input logic [BW*R-1:0] av, input logic last, input logic keep);
        int t;
        act_in = av;
        act_last = last;
        keep_wt = keep;
        act_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!act_ready && t < 50) begin @(negedge clk); t++; end
        chk("act_accept", act_ready, 1'b1);
        exp_data_q.push_back(model(av));
        exp_last_q.push_back(last);
        exp_due_q.push_back(cyc + 1 + L);
        @(posedge clk); #1;
        act_valid = 1'b0;
        act_last = 1'b0;
        keep_wt = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_data_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
        chk("drain_done", exp_data_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_w();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) mw[r][c] = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lc;
        mw = '{default: '0};
        // reset state
        #12;
        chk("rst_wt_ready", wt_ready, 1'b0);
        chk("rst_act_ready", act_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("wt_ready_before_edge", wt_ready, 1'b0);
        @(posedge clk); #1;
        chk("wt_ready_after_edge", wt_ready, 1'b1);

        // small unsigned tile embedded in the full array
        mw[0][0] = 8'd1; mw[0][1] = 8'd2; mw[1][0] = 8'd3; mw[1][1] = 8'd4;
        load_w(1'b0, 1'b0);
        chk("t1_busy_ready", busy, 1'b1);
        send_vec(32'h0000_0101, 1'b0, 1'b0);
        send_vec(32'h0000_0002, 1'b1, 1'b0);
        wait_drain();
        chk("t1_busy_idle", busy, 1'b0);
        chk("t1_wt_ready_idle", wt_ready, 1'b1);

        // signed corner operands, then the same bits unsigned
        mw = '{default: '0};
        mw[0][0] = 8'hFF; mw[0][1] = 8'd127; mw[1][0] = 8'h80; mw[1][1] = 8'd1;
        load_w(1'b1, 1'b1);
        send_vec(32'h0000_FFFF, 1'b1, 1'b0);
        wait_drain();
        load_w(1'b0, 1'b0);
        send_vec(32'h0000_FFFF, 1'b1, 1'b0);
        wait_drain();

        // weight retention across tiles, ignored weight beat in READY, bubbles
        rand_w();
        load_w(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_vec($urandom, i == 4, 1'b1);
        wait_drain();
        chk("t3_busy_kept", busy, 1'b1);
        chk("t3_act_ready_kept", act_ready, 1'b1);
        chk("t3_wt_ready_kept", wt_ready, 1'b0);
        wt_valid = 1'b1; wt_in = {4{$urandom}};
        @(negedge clk);
        chk("t3_wt_ready_in_ready", wt_ready, 1'b0);
        @(posedge clk); #1;
        wt_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_vec($urandom, i == 4, 1'b0);
            if (i[0] == 1'b0) begin @(posedge clk); #1; end
        end
        wait_drain();
        chk("t3_busy_released", busy, 1'b0);
        chk("t3_wt_ready_released", wt_ready, 1'b1);

        // full-size random signed stream, back to back
        rand_w();
        load_w(1'b1, 1'b0);
        lc = last_cnt;
        for (int i = 0; i < 100; i++) send_vec($urandom, i == 99, 1'b0);
        wait_drain();
        chk("t5_one_last", last_cnt - lc, 1);

        // reset during drain with vectors in flight
        rand_w();
        load_w(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_vec($urandom, i == 2, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_last", out_last, 1'b0);
        chk("t6_out_data", out_data, '0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_wt_ready", wt_ready, 1'b0);
        exp_data_q.delete();
        exp_last_q.delete();
        exp_due_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("t6_wt_ready_before_edge", wt_ready, 1'b0);
        @(posedge clk); #1;
        chk("t6_wt_ready_after_edge", wt_ready, 1'b1);
        repeat (2*L) @(posedge clk);
        #1 chk("sb_empty", exp_data_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
